free_list_ctrl: RTL and testbench
=================================

Name: free_list_ctrl

Overview:
- Physical-register free-list controller for the N-way R10K-style rename stage.
- Supplies up to `N_WAY` free PR tags per cycle to `map_table` (its `pr_freelist` input) and reclaims Told tags at retirement.
- Raises a dispatch stall when too few tags are free.
- Restores speculative allocations on squash using a retirement (architectural) head pointer.

Parameters:
- `N_WAY`, 3, dispatch/retire width.
- `N_PR`, 64, number of physical registers (`CDB_BITS` = log2(`N_PR`) = 6).
- `N_AR`, 32, number of architectural registers.
- `FL_DEPTH`, `N_PR`-`N_AR` = 32, free-list capacity (power of two).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dis_req[N_WAY]`  in  1 each  slot i dispatches an instruction needing a new PR.
- `pr_freelist[N_WAY]`  out  `CDB_BITS` each  PR assigned to slot i, to `map_table` and ROB.
- `dis_stall`  out  1  insufficient free PRs; nothing is allocated this cycle.
- `rt_valid[N_WAY]`  in  1 each  slot i retires an instruction that had a destination.
- `rt_told[N_WAY]`  in  `CDB_BITS` each  Told PR freed by retiring slot i.
- `squash`  in  1  mispredict/exception flush; discard all speculative allocations.
- `free_count`  out  log2(`FL_DEPTH`)+1  number of free PRs currently available.

Behaviour:
- Storage:
  - `FL_DEPTH`-entry circular buffer of PR tags.
  - Three pointers, each log2(`FL_DEPTH`)+1 bits with a wrap bit: `head` (speculative pop), `arch_head` (retired pop), `tail` (push).
- Reset (`reset`=0, asynchronous):
  - `entry[k]` = `N_AR`+k (PRs 32..63).
  - `head` = `arch_head` = 0, `tail` = `FL_DEPTH` (wrap bit 1, index 0).
  - `free_count` = 32, `dis_stall` = 0.
  - `pr_freelist[i]` = `entry[i]` (32,33,34), since all outputs are combinational from state.
- Reset is honoured mid-operation; all in-flight requests are dropped.
- `free_count` = `tail` − `head`, modulo 2·`FL_DEPTH`; full = 32, empty = 0.
- Compaction:
  - `req_cnt` = popcount(`dis_req`).
  - Slot i receives `entry[head + popcount(dis_req[0..i-1])]`.
  - Non-requesting slots output 0.
  - Outputs are combinational in the same cycle (0-cycle latency), so `map_table` samples them at the same edge it writes.
- Stall: `dis_stall` = (`req_cnt` > `free_count`), combinational, all-or-nothing.
  - When `dis_stall`=1, `head` is unchanged, and `pr_freelist` values are still driven but must be ignored.
- Dispatch commit at posedge: if `!squash && !dis_stall`, `head` += `req_cnt`.
- Retire at posedge, independent of stall:
  - For each valid slot in order 0..N-1, write `rt_told` to `entry[tail + popcount(rt_valid[0..i-1])]`.
  - `tail` += popcount(`rt_valid`).
  - `arch_head` += popcount(`rt_valid`).
- Squash at posedge:
  - `head` <= `arch_head`_next, i.e. `arch_head` including same-cycle retirement.
  - Dispatch is ignored that cycle.
  - Retirement in the same cycle is still applied.
- Same-cycle retire and dispatch: freed tags are NOT visible to dispatch until the next cycle. `free_count` and stall use registered `tail`.
- Overflow: `tail` − `head` + popcount(`rt_valid`) > `FL_DEPTH` cannot occur in a correct core. Guard it with an assertion; behaviour is then undefined.
- Wrap-around: index = pointer[log2(`FL_DEPTH`)-1:0]; multi-slot pops and pushes span the wrap boundary transparently.
- x0: upstream deasserts `dis_req` and `rt_valid` for dest x0; this block does not filter them.

Decomposition:
- `sys_defs` package holds `N_WAY`, `N_PR`, `N_AR`, `CDB_BITS`, `FL_DEPTH`, and a `FL_PTR` typedef (pointer with wrap bit).
- Natural sub-module: `prefix_popcount`, the N-way exclusive prefix count shared by the dispatch compaction and the retire push.

Test Plan:
- Reset: release `reset` → `free_count`=32, `pr_freelist`={32,33,34}, `dis_stall`=0.
- Dispatch: `dis_req`={1,0,1} for one cycle → outputs {32,0,33} that cycle; next cycle `free_count`=30, `pr_freelist[0]`=34.
- Exhaustion: 10 cycles of `dis_req`=3'b111 consume 30 PRs (`free_count`=2), then `dis_req`=3'b111 → `dis_stall`=1, `head` unchanged. With `dis_req`=3'b011 → no stall, `free_count` goes to 0.
- Retire and wrap:
  - Starting from `free_count`=0, retire `rt_told`={2,5,8} all valid → `free_count`=3.
  - Dispatch 3 → PRs {2,5,8}, taken from indices 0..2 after the wrap.
- Squash: dispatch 6 PRs (32..37), retire 1 (Told 4), assert `squash` with `dis_req`=3'b111 in the same cycle → next cycle `head`=`arch_head`=1, `free_count`=32, `pr_freelist[0]`=33.
- Async reset mid-burst: pull `reset` low between clock edges while `dis_req`=3'b111 → outputs return to reset values immediately, with no edge required.

Source files
------------

// File: rtl/free_list_ctrl_pkg.sv
// Shared sizes and types for the rename-stage physical-register free list.
package free_list_ctrl_pkg;

    localparam int N_WAY       = 3;
    localparam int N_PR        = 64;
    localparam int N_AR        = 32;
    localparam int CDB_BITS    = $clog2(N_PR);
    localparam int FL_DEPTH    = N_PR - N_AR;
    localparam int FL_IDX_BITS = $clog2(FL_DEPTH);
    localparam int CNT_BITS    = $clog2(N_WAY + 1);

    // Ring pointer: index bits plus one wrap bit so full and empty differ
    typedef logic [FL_IDX_BITS:0]   FL_PTR;
    typedef logic [FL_IDX_BITS-1:0] fl_idx_t;
    typedef logic [CDB_BITS-1:0]    pr_tag_t;
    typedef logic [CNT_BITS-1:0]    way_cnt_t;

    // Ring index addressed by a wrap-bit pointer
    function automatic fl_idx_t ptr_idx(input FL_PTR p);
        return p[FL_IDX_BITS-1:0];
    endfunction

endpackage

// File: rtl/free_list_ctrl_if.sv
// Dispatch / retire / squash bundle between the rename core and the free list.
interface free_list_ctrl_if;
    import free_list_ctrl_pkg::*;

    logic    [N_WAY-1:0] dis_req;
    pr_tag_t [N_WAY-1:0] pr_freelist;
    logic                dis_stall;
    logic    [N_WAY-1:0] rt_valid;
    pr_tag_t [N_WAY-1:0] rt_told;
    logic                squash;
    FL_PTR               free_count;

    modport master (
        output dis_req, rt_valid, rt_told, squash,
        input  pr_freelist, dis_stall, free_count
    );

    modport slave (
        input  dis_req, rt_valid, rt_told, squash,
        output pr_freelist, dis_stall, free_count
    );

endinterface

// File: rtl/free_list_ctrl_chk.sv
// Runtime checks on the free-list pointer arithmetic.
module free_list_ctrl_chk
    import free_list_ctrl_pkg::*;
(
    input logic     clock,
    input logic     reset,
    input FL_PTR    free_count,
    input way_cnt_t rt_cnt
);

    localparam int SUM_W = FL_IDX_BITS + 2;
    typedef logic [SUM_W-1:0] sum_t;

    // Retirement can only return tags that were handed out, so the ring never overfills
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        (sum_t'(free_count) + sum_t'(rt_cnt)) <= sum_t'(FL_DEPTH));

endmodule

// File: rtl/free_list_ctrl_prefix_popcount.sv
// Exclusive prefix population count over the N_WAY slot mask.
module free_list_ctrl_prefix_popcount
    import free_list_ctrl_pkg::*;
(
    input  logic     [N_WAY-1:0] vec,
    output way_cnt_t [N_WAY-1:0] prefix,
    output way_cnt_t             total
);

    way_cnt_t acc_s;

    // Slot i sees how many lower slots are set; total is the full count
    always_comb begin
        acc_s  = '0;
        prefix = '0;
        for (int i = 0; i < N_WAY; i++) begin
            prefix[i] = acc_s;
            acc_s     = acc_s + way_cnt_t'(vec[i]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/free_list_ctrl.sv
// R10K-style physical-register free list: N-way compacted pop, in-order push
// at retirement, and squash recovery from the retired (architectural) head.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
(
    input logic            clock,
    input logic            reset,
    free_list_ctrl_if.slave fl_if
);

    pr_tag_t entry_q [FL_DEPTH];
    pr_tag_t entry_d [FL_DEPTH];
    FL_PTR   head_q, head_d;
    FL_PTR   arch_head_q, arch_head_d;
    FL_PTR   tail_q, tail_d;

    way_cnt_t [N_WAY-1:0] dis_pre_s;
    way_cnt_t [N_WAY-1:0] rt_pre_s;
    way_cnt_t             req_cnt_s;
    way_cnt_t             rt_cnt_s;
    FL_PTR                free_count_s;
    logic                 dis_stall_s;
    pr_tag_t [N_WAY-1:0]  pr_freelist_s;

    free_list_ctrl_prefix_popcount u_dis_cnt (
        .vec    (fl_if.dis_req),
        .prefix (dis_pre_s),
        .total  (req_cnt_s)
    );

    free_list_ctrl_prefix_popcount u_rt_cnt (
        .vec    (fl_if.rt_valid),
        .prefix (rt_pre_s),
        .total  (rt_cnt_s)
    );

    // Availability uses registered tail only: same-cycle frees are not reusable yet
    always_comb begin
        free_count_s = tail_q - head_q;
        dis_stall_s  = FL_PTR'(req_cnt_s) > free_count_s;
    end

    // Compact the requesting slots onto consecutive ring entries from head
    always_comb begin
        pr_freelist_s = '0;
        for (int i = 0; i < N_WAY; i++) begin
            pr_freelist_s[i] = fl_if.dis_req[i]
                             ? entry_q[ptr_idx(head_q + FL_PTR'(dis_pre_s[i]))]
                             : pr_tag_t'(0);
        end
    end

    assign fl_if.pr_freelist = pr_freelist_s;
    assign fl_if.dis_stall   = dis_stall_s;
    assign fl_if.free_count  = free_count_s;

    // Next pointers and ring contents: retire always applies, squash beats dispatch
    always_comb begin
        entry_d     = entry_q;
        tail_d      = tail_q + FL_PTR'(rt_cnt_s);
        arch_head_d = arch_head_q + FL_PTR'(rt_cnt_s);
        for (int i = 0; i < N_WAY; i++) begin
            entry_d[ptr_idx(tail_q + FL_PTR'(rt_pre_s[i]))] =
                fl_if.rt_valid[i] ? fl_if.rt_told[i]
                                  : entry_d[ptr_idx(tail_q + FL_PTR'(rt_pre_s[i]))];
        end
        if (fl_if.squash) begin
            head_d = arch_head_d;
        end else if (!dis_stall_s) begin
            head_d = head_q + FL_PTR'(req_cnt_s);
        end else begin
            head_d = head_q;
        end
    end

    // State registers; reset fills the ring with the non-architectural PRs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= FL_PTR'(FL_DEPTH);
            for (int k = 0; k < FL_DEPTH; k++) begin
                entry_q[k] <= pr_tag_t'(N_AR + k);
            end
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            entry_q     <= entry_d;
        end
    end

    free_list_ctrl_chk u_chk (
        .clock      (clock),
        .reset      (reset),
        .free_count (free_count_s),
        .rt_cnt     (rt_cnt_s)
    );

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios followed by
// random dispatch/retire/squash traffic against a queue-based reference.
module tb_free_list_ctrl;
    import free_list_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;

    free_list_ctrl_if fl_if ();

    free_list_ctrl dut (
        .clock (clock),
        .reset (reset),
        .fl_if (fl_if)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: fl_q holds the 32 ring tags in order starting at the retired
    // head; spec_n of them have been handed out speculatively.
    int fl_q[$];
    int spec_n;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl_q.delete();
        for (int k = 0; k < FL_DEPTH; k++) fl_q.push_back(N_AR + k);
        spec_n = 0;
    endtask

    // Compare the combinational outputs for the inputs currently applied
    task automatic check_outputs(input string tag, output bit stall);
        int req_cnt;
        int free;
        int rank;
        int exp_pr;
        req_cnt = $countones(fl_if.dis_req);
        free    = FL_DEPTH - spec_n;
        stall   = (req_cnt > free);
        chk({tag, ".free_count"}, int'(fl_if.free_count), free);
        chk({tag, ".dis_stall"}, int'(fl_if.dis_stall), int'(stall));
        if (!stall) begin
            rank = 0;
            for (int i = 0; i < N_WAY; i++) begin
                if (fl_if.dis_req[i]) begin
                    exp_pr = fl_q[(spec_n + rank) % FL_DEPTH];
                    rank++;
                end else begin
                    exp_pr = 0;
                end
                chk($sformatf("%s.pr%0d", tag, i), int'(fl_if.pr_freelist[i]), exp_pr);
            end
        end
    endtask

    // One clock: drive at negedge, check before the edge, advance the model at the edge
    task automatic cycle(input string tag, input logic [2:0] req, input logic [2:0] rtv,
                         input int t0, input int t1, input int t2, input bit sq);
        bit stall;
        int told[3];
        int req_cnt;
        told[0] = t0; told[1] = t1; told[2] = t2;
        @(negedge clock);
        fl_if.dis_req    = req;
        fl_if.rt_valid   = rtv;
        fl_if.rt_told[0] = pr_tag_t'(t0);
        fl_if.rt_told[1] = pr_tag_t'(t1);
        fl_if.rt_told[2] = pr_tag_t'(t2);
        fl_if.squash     = sq;
        #1;
        check_outputs(tag, stall);
        @(posedge clock);
        req_cnt = $countones(req);
        if (!sq && !stall) spec_n += req_cnt;
        for (int i = 0; i < N_WAY; i++) begin
            if (rtv[i]) begin
                void'(fl_q.pop_front());
                fl_q.push_back(told[i]);
                spec_n--;
            end
        end
        if (sq) spec_n = 0;
    endtask

    task automatic idle_inputs();
        fl_if.dis_req  = 3'b000;
        fl_if.rt_valid = 3'b000;
        fl_if.rt_told  = '0;
        fl_if.squash   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        bit   stall;
        logic [2:0] req;
        logic [2:0] rtv;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Reset state, then a compacted two-slot dispatch
        cycle("reset", 3'b111, 3'b000, 0, 0, 0, 1'b0);
        do_reset();
        cycle("disp101", 3'b101, 3'b000, 0, 0, 0, 1'b0);
        cycle("disp001", 3'b001, 3'b000, 0, 0, 0, 1'b0);

        // Exhaustion: 30 tags, then a stalled 3-wide request, then the last 2
        do_reset();
        for (int c = 0; c < 10; c++) cycle($sformatf("exh%0d", c), 3'b111, 3'b000, 0, 0, 0, 1'b0);
        cycle("stall", 3'b111, 3'b000, 0, 0, 0, 1'b0);
        cycle("last2", 3'b011, 3'b000, 0, 0, 0, 1'b0);
        // Retire into an empty list: the freed tags are not visible this cycle
        cycle("rt258", 3'b111, 3'b111, 2, 5, 8, 1'b0);
        cycle("wrapdisp", 3'b111, 3'b000, 0, 0, 0, 1'b0);
        cycle("empty", 3'b000, 3'b000, 0, 0, 0, 1'b0);

        // Squash with a same-cycle retirement and dispatch request
        do_reset();
        cycle("sq_a", 3'b111, 3'b000, 0, 0, 0, 1'b0);
        cycle("sq_b", 3'b111, 3'b000, 0, 0, 0, 1'b0);
        cycle("sq", 3'b111, 3'b001, 4, 0, 0, 1'b1);
        cycle("post_sq", 3'b001, 3'b000, 0, 0, 0, 1'b0);

        // Random traffic: retire only what has been handed out
        for (int c = 0; c < 400; c++) begin
            req = 3'($urandom_range(0, 7));
            rtv = 3'($urandom_range(0, 7));
            if ($countones(rtv) > spec_n) rtv = 3'b000;
            cycle($sformatf("rnd%0d", c), req, rtv, $urandom_range(0, 63),
                  $urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges while a 3-wide request is held
        @(negedge clock);
        fl_if.dis_req = 3'b111;
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("arst", stall);
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        cycle("after_arst", 3'b010, 3'b000, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
